// File: rtl/vend_pkg.sv
// Shared coin table, FSM state type and one-hot helpers for the vending core.
package vend_pkg;
    localparam int unsigned NUM_DENOM   = 5;
    localparam int unsigned DENOM_IDX_W = 3;
    localparam int unsigned DENOM [NUM_DENOM] = '{5, 10, 20, 50, 100};

    typedef enum logic [1:0] {IDLE, DISPENSE, CHANGE} state_t;

    function automatic logic is_onehot(input logic [NUM_DENOM-1:0] v);
        return (v != '0) && ((v & (v - NUM_DENOM'(1))) == '0);
    endfunction

    function automatic logic [DENOM_IDX_W-1:0] onehot_idx(input logic [NUM_DENOM-1:0] v);
        logic [DENOM_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_DENOM; i++)
            if (v[i]) idx = DENOM_IDX_W'(i);
        return idx;
    endfunction
endpackage

// File: rtl/vend_change_gen.sv
// Greedy change selector: picks the largest coin that fits the remaining balance and
// counts coins paid per denomination (counters saturate; a full counter blocks its coin).
module vend_change_gen
    import vend_pkg::*;
#(
    parameter int unsigned PRICE_W = 8,
    parameter int unsigned CNT_W   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       step,
    input  logic [PRICE_W-1:0]         bal,
    input  logic [NUM_DENOM-1:0]       avail,
    output logic                       pick_valid_c,
    output logic [DENOM_IDX_W-1:0]     pick_idx_c,
    output logic [NUM_DENOM*CNT_W-1:0] chg_count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt [NUM_DENOM];

    // Ascending scan so the last fitting denomination (the largest) wins.
    always_comb begin
        pick_valid_c = 1'b0;
        pick_idx_c   = '0;
        for (int i = 0; i < NUM_DENOM; i++) begin
            if (avail[i] && (cnt[i] != CNT_MAX) && (32'(bal) >= DENOM[i])) begin
                pick_valid_c = 1'b1;
                pick_idx_c   = DENOM_IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DENOM; i++) cnt[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_DENOM; i++) cnt[i] <= '0;
        end else if (step) begin
            cnt[pick_idx_c] <= cnt[pick_idx_c] + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_DENOM; g++) begin : g_cnt
        assign chg_count[g*CNT_W +: CNT_W] = cnt[g];
    end
endmodule

// File: rtl/vend_core_param.sv
// Parametrised vending core: coins, balance, selection, stock, dispense handshake, greedy change.
// Define VEND_CHANGE_INV_EN to track per-denomination hopper inventory for change payout.
module vend_core_param
    import vend_pkg::*;
#(
    parameter int unsigned N_PROD       = 10,
    parameter int unsigned PRICE_W      = 8,
    parameter int unsigned QTY_W        = 4,
    parameter int unsigned CNT_W        = 4,
    parameter int unsigned BAL_MAX      = 200,
    parameter int unsigned DISP_TIMEOUT = 1000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        coin_valid,
    input  logic [NUM_DENOM-1:0]        coin_sel,
    input  logic                        sel_valid,
    input  logic [$clog2(N_PROD)-1:0]   sel_code,
    input  logic [N_PROD*PRICE_W-1:0]   price_all,
    input  logic                        load_qty,
    input  logic [N_PROD*QTY_W-1:0]     init_qty,
    input  logic                        disp_ack,
    input  logic                        refund,
    output logic [PRICE_W-1:0]          balance,
    output logic                        coin_reject,
    output logic                        max_balance,
    output logic                        out_of_stock,
    output logic                        low_balance,
    output logic                        disp_req,
    output logic [$clog2(N_PROD)-1:0]   disp_code,
    output logic                        no_taker,
    output logic                        chg_valid,
    output logic [NUM_DENOM*CNT_W-1:0]  chg_count,
    output logic                        chg_short,
    output logic                        busy
);
    localparam int unsigned SEL_W = $clog2(N_PROD);
    localparam int unsigned TMR_W = $clog2(DISP_TIMEOUT + 1);

    state_t                 state;
    logic [QTY_W-1:0]       stock     [N_PROD];
    logic [PRICE_W-1:0]     price_arr [N_PROD];
    logic [PRICE_W-1:0]     price_lat;
    logic [TMR_W-1:0]       timer;
    logic [NUM_DENOM-1:0]   avail;
    logic                   sel_ok_c, sel_take_c, coin_take_c, coin_ok_c, coin_over_c;
    logic                   chg_clear_c, chg_step_c, pick_valid_c;
    logic [SEL_W-1:0]       sel_idx_c;
    logic [DENOM_IDX_W-1:0] coin_idx_c, pick_idx_c;
    logic [PRICE_W:0]       coin_sum_c;

    for (genvar g = 0; g < N_PROD; g++) begin : g_price
        assign price_arr[g] = price_all[g*PRICE_W +: PRICE_W];
    end

    // IDLE arbitration: load_qty > refund > sel_valid > coin_valid.
    always_comb begin
        sel_ok_c    = 32'(sel_code) < N_PROD;
        sel_idx_c   = sel_ok_c ? sel_code : '0;
        coin_idx_c  = onehot_idx(coin_sel);
        coin_sum_c  = (PRICE_W+1)'(balance) + (PRICE_W+1)'(DENOM[coin_idx_c]);
        coin_over_c = 32'(coin_sum_c) > BAL_MAX;
        sel_take_c  = (state == IDLE) && !load_qty && !refund && sel_valid && sel_ok_c;
        coin_take_c = (state == IDLE) && !load_qty && !refund && !sel_take_c &&
                      coin_valid && is_onehot(coin_sel);
        coin_ok_c   = coin_take_c && !coin_over_c;
        chg_clear_c = (state == IDLE) && !load_qty && refund;
        chg_step_c  = (state == CHANGE) && pick_valid_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            balance      <= '0;
            price_lat    <= '0;
            timer        <= '0;
            disp_req     <= 1'b0;
            disp_code    <= '0;
            coin_reject  <= 1'b0;
            max_balance  <= 1'b0;
            out_of_stock <= 1'b0;
            low_balance  <= 1'b0;
            no_taker     <= 1'b0;
            chg_valid    <= 1'b0;
            chg_short    <= 1'b0;
            for (int p = 0; p < N_PROD; p++) stock[p] <= '0;
        end else begin
            coin_reject  <= coin_valid && !coin_ok_c;
            max_balance  <= coin_take_c && coin_over_c;
            out_of_stock <= 1'b0;
            low_balance  <= 1'b0;
            no_taker     <= 1'b0;
            chg_valid    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load_qty) begin
                        for (int p = 0; p < N_PROD; p++) stock[p] <= init_qty[p*QTY_W +: QTY_W];
                    end else if (refund) begin
                        state <= CHANGE;
                        busy  <= 1'b1;
                    end else if (sel_take_c) begin
                        if (stock[sel_idx_c] == '0) begin
                            out_of_stock <= 1'b1;
                        end else if (balance < price_arr[sel_idx_c]) begin
                            low_balance <= 1'b1;
                        end else begin
                            state     <= DISPENSE;
                            busy      <= 1'b1;
                            disp_req  <= 1'b1;
                            disp_code <= sel_idx_c;
                            price_lat <= price_arr[sel_idx_c];
                            timer     <= '0;
                        end
                    end else if (coin_ok_c) begin
                        balance <= balance + PRICE_W'(DENOM[coin_idx_c]);
                    end
                end
                DISPENSE: begin
                    if (disp_ack) begin
                        balance  <= balance - price_lat;
                        if (stock[disp_code] != '0) stock[disp_code] <= stock[disp_code] - QTY_W'(1);
                        disp_req <= 1'b0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else if (32'(timer) >= DISP_TIMEOUT - 1) begin
                        no_taker <= 1'b1;
                        disp_req <= 1'b0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                CHANGE: begin
                    if (pick_valid_c) begin
                        balance <= balance - PRICE_W'(DENOM[pick_idx_c]);
                    end else begin
                        chg_valid <= 1'b1;
                        chg_short <= balance != '0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VEND_CHANGE_INV_EN
    logic [CNT_W-1:0] inv [NUM_DENOM];

    // Hopper fills from accepted coins (saturating) and drains as change is paid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DENOM; i++) inv[i] <= '0;
        end else if (coin_ok_c) begin
            if (inv[coin_idx_c] != '1) inv[coin_idx_c] <= inv[coin_idx_c] + CNT_W'(1);
        end else if (chg_step_c) begin
            inv[pick_idx_c] <= inv[pick_idx_c] - CNT_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_DENOM; g++) begin : g_avail
        assign avail[g] = inv[g] != '0;
    end
`else
    assign avail = '1;
`endif

    vend_change_gen #(
        .PRICE_W (PRICE_W),
        .CNT_W   (CNT_W)
    ) u_change (
        .clk          (clk),
        .reset        (reset),
        .clear        (chg_clear_c),
        .step         (chg_step_c),
        .bal          (balance),
        .avail        (avail),
        .pick_valid_c (pick_valid_c),
        .pick_idx_c   (pick_idx_c),
        .chg_count    (chg_count)
    );
endmodule
